booth_mul_seq: RTL and testbench

Parametrised, iterative radix-4 Booth multiplier for the EX stage of the 5-stage pipeline. It replaces the fixed 32-bit combinational low-word multiplier.
- Supports all four RV32M multiply ops: MUL, MULH, MULHSU, MULHU.
- Valid/ready handshakes on input and output.
- Processes one radix-4 partial product per cycle.
- Flush input lets the pipeline kill an in-flight multiply.

---
 rtl/mul_pkg.sv | 24 ++
 rtl/booth_r4_digit.sv | 33 +++
 rtl/booth_mul_seq.sv | 182 ++++++++++++++++++
 tb/tb_booth_mul_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier.
//   OP_*    : RV32M multiply operation encodings (in_op)
//   state_e : control FSM states
//   iter_f  : number of radix-4 steps needed for a given operand width
package mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;  // low word, sign irrelevant
  localparam logic [1:0] OP_MULH   = 2'b01;  // signed x signed, high word
  localparam logic [1:0] OP_MULHSU = 2'b10;  // signed x unsigned, high word
  localparam logic [1:0] OP_MULHU  = 2'b11;  // unsigned x unsigned, high word

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // Operands are extended by two bits so that signed and unsigned ops share
  // one signed datapath; every step retires two multiplier bits.
  function automatic int iter_f(input int width);
    return (width / 2) + 1;
  endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Radix-4 Booth digit selector (combinational).
// Ports:
//   a_i    [WIDTH+1:0] : extended multiplicand (two's complement)
//   trip_i [2:0]       : multiplier triplet {b[2i+1], b[2i], b[2i-1]}
//   pp_o   [WIDTH+3:0] : partial product, one of 0, +a, -a, +2a, -2a
module booth_r4_digit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] a_i,
  input  logic [2:0]       trip_i,
  output logic [WIDTH+3:0] pp_o
);

  logic [WIDTH+3:0] a1_s;
  logic [WIDTH+3:0] a2_s;

  // Sign-extend a and form 2a; the two spare bits keep -2a representable.
  assign a1_s = {{2{a_i[WIDTH+1]}}, a_i};
  assign a2_s = {a1_s[WIDTH+2:0], 1'b0};

  // Triplet decode to the signed partial product.
  always_comb begin
    pp_o = {(WIDTH+4){1'b0}};
    case (trip_i)
      3'b001, 3'b010: pp_o = a1_s;
      3'b011:         pp_o = a2_s;
      3'b100:         pp_o = -a2_s;
      3'b101, 3'b110: pp_o = -a1_s;
      default:        pp_o = {(WIDTH+4){1'b0}};
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier supporting MUL/MULH/MULHSU/MULHU.
// One partial product is accumulated per cycle; valid/ready on both sides.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   flush                 : kill any operation, highest priority
//   in_valid/in_ready     : operation handshake (in_op, in_a, in_b, in_tag)
//   out_valid/out_ready   : result handshake (out_result, out_tag)
// Optional build macro BOOTH_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are pure sign extension (variable latency, same results).
module booth_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int ITER  = iter_f(WIDTH);
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int EW    = WIDTH + 2;
  localparam int PW    = 2 * WIDTH + 4;

  state_e           state_q, state_d;
  logic [EW-1:0]    a_q, a_d;
  logic [EW-1:0]    b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic [CNT_W:0]   shamt_s;
  logic [EW:0]      bx_s;
  logic [2:0]       trip_s;
  logic [WIDTH+3:0] pp_s;
  logic [PW-1:0]    pp_ext_s;
  logic [PW-1:0]    step_s;
  logic [WIDTH-1:0] res_sel_s;
  logic             last_s;
  logic             a_sgn_s;
  logic             b_sgn_s;

  // Step i works on b bits [2i+1:2i-1]; b[-1]=0 is the appended zero.
  assign shamt_s = {cnt_q, 1'b0};
  assign bx_s    = {b_q, 1'b0};
  assign trip_s  = bx_s[shamt_s +: 3];

  booth_r4_digit #(
    .WIDTH (WIDTH)
  ) u_digit (
    .a_i    (a_q),
    .trip_i (trip_s),
    .pp_o   (pp_s)
  );

  // Weight the digit by 4^i and accumulate into the full-width product.
  assign pp_ext_s  = {{WIDTH{pp_s[WIDTH+3]}}, pp_s};
  assign step_s    = prod_q + (pp_ext_s << shamt_s);
  assign res_sel_s = (op_q == OP_MUL) ? step_s[WIDTH-1:0] : step_s[2*WIDTH-1:WIDTH];

`ifdef BOOTH_EARLY_TERM_EN
  logic [EW-1:0] rem_s;
  // Bits from this step's top bit upward; all equal to the sign means every
  // remaining triplet is 000 or 111 and contributes nothing.
  assign rem_s  = $signed(b_q) >>> {cnt_q, 1'b1};
  assign last_s = (cnt_q == CNT_W'(ITER - 1)) || (rem_s == {EW{b_q[EW-1]}});
`else
  assign last_s = (cnt_q == CNT_W'(ITER - 1));
`endif

  // a is signed except for MULHU; b is signed only for MUL and MULH.
  assign a_sgn_s = (in_op != OP_MULHU);
  assign b_sgn_s = (in_op == OP_MUL) || (in_op == OP_MULH);

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    tag_d        = tag_q;
    cnt_d        = cnt_q;
    prod_d       = prod_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_d     = {{2{a_sgn_s & in_a[WIDTH-1]}}, in_a};
            b_d     = {{2{b_sgn_s & in_b[WIDTH-1]}}, in_b};
            op_d    = in_op;
            tag_d   = in_tag;
            cnt_d   = {CNT_W{1'b0}};
            prod_d  = {PW{1'b0}};
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          prod_d = step_s;
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_s) begin
            out_result_d = res_sel_s;
            out_tag_d    = tag_q;
            state_d      = DONE;
          end else begin
            state_d = BUSY;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= {EW{1'b0}};
      b_q          <= {EW{1'b0}};
      op_q         <= 2'b00;
      tag_q        <= {TAG_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      prod_q       <= {PW{1'b0}};
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= {WIDTH{1'b0}};
      out_tag_q    <= {TAG_W{1'b0}};
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      cnt_q        <= cnt_d;
      prod_q       <= prod_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed self-checking bench for booth_mul_seq (WIDTH=32, TAG_W=5).
module tb_booth_mul_seq;

  localparam int W  = 32;
  localparam int TW = 5;

`ifdef BOOTH_EARLY_TERM_EN
  localparam int LAT_B1 = 1;
`else
  localparam int LAT_B1 = 17;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_mul_seq #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operation, wait for its accept edge, then scramble inputs.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [TW-1:0] tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", in_ready, 1'b1);
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~a; in_b = 32'h0000_0000; in_op = ~op; in_tag = ~tag;
  endtask

  // Count edges from the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("result_timeout", out_valid, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] tag,
                        input logic [W-1:0] exp);
    int lat;
    start_op(op, a, b, tag);
    wait_result(lat);
    check(name, out_result, exp);
    check({name, "_tag"}, out_tag, tag);
    @(posedge clk); #1;
  endtask

  // Watch a window of cycles in which no result may appear.
  task automatic expect_quiet(input string name, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check(name, seen, 1'b0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_tag", out_tag, 5'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MULHU -1u * -1u with latency, then MUL on the same operands.
    start_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h01);
    wait_result(lat);
    check("mulhu_lat", lat, 17);
    check("mulhu_ff", out_result, 32'hFFFF_FFFE);
    check("mulhu_tag", out_tag, 5'h01);
    @(posedge clk); #1;
    run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h02, 32'h0000_0001);

    // Signed corner cases.
    run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'h03, 32'h4000_0000);
    run_op("mulh_m1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h04, 32'h0000_0000);
    run_op("mul_min", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'h05, 32'h8000_0000);
    run_op("mulh_neg", 2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 5'h06, 32'hFFFF_FFFF);
    run_op("mulhu_2p32", 2'b11, 32'h0001_0000, 32'h0001_0000, 5'h07, 32'h0000_0001);
    run_op("mul_2p32", 2'b00, 32'h0001_0000, 32'h0001_0000, 5'h08, 32'h0000_0000);
    run_op("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, 32'hFFFF_FFFF);

    // Backpressure: result held stable while out_ready is low.
    out_ready = 1'b0;
    start_op(2'b00, 32'h0000_0003, 32'h0000_0005, 5'h0A);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1'b1);
      check("bp_result", out_result, 32'd15);
      check("bp_tag", out_tag, 5'h0A);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", in_ready, 1'b1);
    check("bp_release_valid", out_valid, 1'b0);

    // Flush together with in_valid in IDLE: nothing is accepted.
    in_op = 2'b00; in_a = 32'd2; in_b = 32'd2; in_tag = 5'h0B;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", in_ready, 1'b1);
    expect_quiet("flush_idle_quiet", 20);

    // Flush at BUSY cycle 8.
    start_op(2'b00, 32'h0000_0003, 32'h7FFF_FFFF, 5'h0C);
    repeat (7) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_valid", out_valid, 1'b0);
    check("flush_busy_ready", in_ready, 1'b1);
    expect_quiet("flush_busy_quiet", 25);
    run_op("mul_after_flush", 2'b00, 32'd7, 32'd6, 5'h0D, 32'd42);

    // Reset pulsed mid-BUSY: outputs return to reset values at once.
    start_op(2'b00, 32'h0000_0005, 32'h7FFF_FFFF, 5'h0E);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rstm_valid", out_valid, 1'b0);
    check("rstm_ready", in_ready, 1'b1);
    check("rstm_result", out_result, 32'h0);
    check("rstm_tag", out_tag, 5'h0);
    #2;
    rst_n = 1'b1;
    expect_quiet("rstm_quiet", 25);
    run_op("mul_after_rst", 2'b00, 32'd7, 32'd6, 5'h11, 32'd42);

    // Small multiplier: early finish when enabled, full latency otherwise.
    start_op(2'b00, 32'h1234_5678, 32'h0000_0001, 5'h12);
    wait_result(lat);
    check("b1_lat", lat, LAT_B1);
    check("b1_result", out_result, 32'h1234_5678);
    check("b1_tag", out_tag, 5'h12);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
